prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter FM_RST_CYCLES, default 2: cycles rst_fm is held high before loading.
REQ-002 SHALL have parameter CPU_RST_CYCLES, default 2: width of the cpu_reset pulse after loading.
REQ-003 SHALL have ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  begin a load session
- base_addr  in  32  first fetch-memory address
- word_count  in  16  number of program words to load
- in_valid  in  1  host word valid
- in_data  in  16  host word
- in_ready  out  1  loader accepts in_data
- rst_fm  out  1  fetch-memory reset, active-high
- write_enable_fm  out  1  fetch-memory write strobe
- write_addr_fm  out  32  fetch-memory write address
- write_data_fm  out  16  fetch-memory write data
- cpu_reset  out  1  processor reset, active-high
- busy  out  1  session in progress
- done  out  1  session complete
- chk_err  out  1  checksum mismatch

Function
REQ-004 SHALL implement FSM states IDLE, FM_RST, LOAD, CHECK (macro only), CPU_RST, DONE.
REQ-005 SHALL accept start only in IDLE or DONE; on acceptance, latch base_addr and word_count, clear done and chk_err, and enter FM_RST. start SHALL be ignored in any other state.
REQ-006 FM_RST SHALL drive rst_fm=1 for exactly FM_RST_CYCLES cycles, then go to LOAD, or to CPU_RST when the latched word_count is 0.
REQ-007 LOAD SHALL drive in_ready=1; in_ready SHALL be 0 in all other states except CHECK.
REQ-008 A handshake (in_valid & in_ready) at edge N SHALL produce, in the cycle after edge N, write_enable_fm=1 for one cycle with write_data_fm=in_data and write_addr_fm=base+index; index starts at 0 and increments per accepted word.
REQ-009 Address arithmetic SHALL be modulo 2^32 (0xFFFFFFFF+1 wraps to 0).
REQ-010 Back-to-back handshakes SHALL sustain one write per cycle; in_valid low SHALL insert no write and no index change.
REQ-011 After the word_count-th handshake, LOAD SHALL exit the next cycle to CHECK (macro) or CPU_RST, with in_ready=0 from that cycle.
REQ-012 CPU_RST SHALL drive cpu_reset=1 for exactly CPU_RST_CYCLES cycles, then enter DONE.
REQ-013 DONE SHALL hold done=1 until the next accepted start.
REQ-014 busy SHALL be 1 in every state except IDLE and DONE.
REQ-015 write_addr_fm and write_data_fm SHALL hold their last values when write_enable_fm=0.

Reset
REQ-016 Assertion of reset SHALL immediately force IDLE, index 0, and all outputs to 0, including mid-session; a partial load SHALL leave no further writes.
REQ-017 After reset deasserts, no activity SHALL occur until start.

Configuration
REQ-018 Macro LOADER_CHECKSUM_EN SHALL enable checksum checking.
REQ-019 With the macro defined: LOAD SHALL sum accepted words modulo 2^16. CHECK SHALL keep in_ready=1 and accept exactly one expected-sum word, which SHALL NOT be written to memory. On a match, go to CPU_RST. On a mismatch, set chk_err=1, skip CPU_RST, and go to DONE. A word_count of 0 SHALL skip CHECK.
REQ-020 Without the macro: no CHECK state and no sum register; chk_err is tied 0.

Verification
REQ-021 reset low mid-idle, then high -> all outputs 0, state IDLE.
REQ-022 base=0x20, count=3, words 0xC95F, 0x639F, 0x1F3D streamed back-to-back -> writes (0x20,C95F), (0x21,639F), (0x22,1F3D) on consecutive cycles. Also: rst_fm high 2 cycles before the writes, cpu_reset high 2 cycles after, then done=1.
REQ-023 Same load with in_valid deasserted for 3 cycles between words 1 and 2 -> no spurious strobes; addresses unchanged.
REQ-024 base=0xFFFFFFFF, count=2 -> writes to 0xFFFFFFFF then 0x00000000.
REQ-025 count=0 -> no write strobe, cpu_reset pulse, done=1; start during LOAD is ignored; reset low after word 1 -> no writes for words 2 and 3.
REQ-026 Macro on, REQ-022 words plus sum 0x4C3B -> cpu_reset pulse, chk_err=0. Sum 0x4C3C instead -> chk_err=1, no cpu_reset, done=1, and only three writes.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader -- streams a program from a host into fetch memory, then
// releases the processor.
//
// Session sequence: IDLE -> FM_RST -> LOAD -> [CHECK] -> CPU_RST -> DONE.
// The fetch memory is held in reset first. Host words are then written to
// consecutive addresses starting at base_addr. Finally a cpu_reset pulse is
// issued.
//
// Optional feature: define LOADER_CHECKSUM_EN to enable checksum checking.
// The host sends one extra word after the program. That word must equal the
// 16-bit wrapping sum of the program words. A mismatch raises chk_err and
// skips the cpu_reset pulse.
//
// Parameters:
//   FM_RST_CYCLES   cycles rst_fm is held before loading (>= 1)
//   CPU_RST_CYCLES  width of the cpu_reset pulse (>= 1)
// Ports:
//   clk              sole clock, rising edge
//   reset            asynchronous, active-low
//   start            begin a session (honoured in IDLE/DONE only)
//   base_addr[31:0]  first fetch-memory address
//   word_count[15:0] number of program words
//   in_valid/in_data/in_ready  host word handshake
//   rst_fm           fetch-memory reset, active-high
//   write_enable_fm/write_addr_fm/write_data_fm  fetch-memory write port
//   cpu_reset        processor reset pulse, active-high
//   busy / done / chk_err  session status
module prog_loader #(
   parameter int FM_RST_CYCLES  = 2,
   parameter int CPU_RST_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [15:0] word_count,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        rst_fm,
   output logic        write_enable_fm,
   output logic [31:0] write_addr_fm,
   output logic [15:0] write_data_fm,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        chk_err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FM_RST  = 3'd1,
      LOAD    = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      CHECK   = 3'd3,
`endif
      CPU_RST = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [31:0] FM_LAST  = 32'(FM_RST_CYCLES - 1);
   localparam logic [31:0] CPU_LAST = 32'(CPU_RST_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [31:0] cnt_reg, cnt_next;       // cycles spent in a timed state
   logic [31:0] base_reg, base_next;
   logic [15:0] count_reg, count_next;
   logic [15:0] idx_reg, idx_next;
   logic        we_reg, we_next;
   logic [31:0] waddr_reg, waddr_next;
   logic [15:0] wdata_reg, wdata_next;
   logic        hs;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0] sum_reg, sum_next;
   logic        chk_err_reg, chk_err_next;
`endif

   assign hs = in_valid & in_ready;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      base_next  = base_reg;
      count_next = count_reg;
      idx_next   = idx_reg;
      we_next    = 1'b0;
      waddr_next = waddr_reg;
      wdata_next = wdata_reg;
`ifdef LOADER_CHECKSUM_EN
      sum_next     = sum_reg;
      chk_err_next = chk_err_reg;
`endif
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               base_next  = base_addr;
               count_next = word_count;
               idx_next   = 16'd0;
               cnt_next   = 32'd0;
               state_next = FM_RST;
`ifdef LOADER_CHECKSUM_EN
               sum_next     = 16'd0;
               chk_err_next = 1'b0;
`endif
            end
         end
         FM_RST: begin
            if (cnt_reg == FM_LAST) begin
               cnt_next   = 32'd0;
               state_next = (count_reg == 16'd0) ? CPU_RST : LOAD;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         LOAD: begin
            if (hs) begin
               we_next    = 1'b1;
               // 32-bit add wraps naturally past 0xFFFFFFFF.
               waddr_next = base_reg + {16'd0, idx_reg};
               wdata_next = in_data;
               idx_next   = idx_reg + 16'd1;
`ifdef LOADER_CHECKSUM_EN
               sum_next = sum_reg + in_data;
`endif
               if (idx_reg == count_reg - 16'd1) begin
                  cnt_next = 32'd0;
`ifdef LOADER_CHECKSUM_EN
                  state_next = CHECK;
`else
                  state_next = CPU_RST;
`endif
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            // The checksum word is consumed here and never written to memory.
            if (hs) begin
               cnt_next = 32'd0;
               if (in_data == sum_reg) begin
                  state_next = CPU_RST;
               end else begin
                  chk_err_next = 1'b1;
                  state_next   = DONE;
               end
            end
         end
`endif
         CPU_RST: begin
            if (cnt_reg == CPU_LAST) begin
               cnt_next   = 32'd0;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 32'd0;
         base_reg  <= 32'd0;
         count_reg <= 16'd0;
         idx_reg   <= 16'd0;
         we_reg    <= 1'b0;
         waddr_reg <= 32'd0;
         wdata_reg <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
         sum_reg     <= 16'd0;
         chk_err_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         base_reg  <= base_next;
         count_reg <= count_next;
         idx_reg   <= idx_next;
         we_reg    <= we_next;
         waddr_reg <= waddr_next;
         wdata_reg <= wdata_next;
`ifdef LOADER_CHECKSUM_EN
         sum_reg     <= sum_next;
         chk_err_reg <= chk_err_next;
`endif
      end
   end

`ifdef LOADER_CHECKSUM_EN
   assign in_ready = (state_reg == LOAD) || (state_reg == CHECK);
   assign chk_err  = chk_err_reg;
`else
   assign in_ready = (state_reg == LOAD);
   assign chk_err  = 1'b0;
`endif
   assign rst_fm          = (state_reg == FM_RST);
   assign cpu_reset       = (state_reg == CPU_RST);
   assign busy            = (state_reg != IDLE) && (state_reg != DONE);
   assign done            = (state_reg == DONE);
   assign write_enable_fm = we_reg;
   assign write_addr_fm   = waddr_reg;
   assign write_data_fm   = wdata_reg;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- directed bench for prog_loader.
// A negedge monitor logs every write strobe (address, data, cycle) and counts
// rst_fm / cpu_reset cycles. Each scenario snapshots the log before it runs
// and checks only its own deltas. Build with +define+LOADER_CHECKSUM_EN to
// cover the checksum variant.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = 32'd0;
   logic [15:0] word_count = 16'd0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'd0;
   logic        in_ready, rst_fm, write_enable_fm, cpu_reset, busy, done, chk_err;
   logic [31:0] write_addr_fm;
   logic [15:0] write_data_fm;

   int errors = 0;
   int checks = 0;

   prog_loader #(.FM_RST_CYCLES(2), .CPU_RST_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .rst_fm(rst_fm), .write_enable_fm(write_enable_fm),
      .write_addr_fm(write_addr_fm), .write_data_fm(write_data_fm),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .chk_err(chk_err)
   );

   always #5 clk = ~clk;

   // Monitor
   logic [31:0] wa_q[$];
   logic [15:0] wd_q[$];
   int          wc_q[$];
   int cyc = 0, fm_cnt = 0, cpu_cnt = 0, last_fm_cyc = 0, first_cpu_cyc = 0;
   logic cpu_prev = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (write_enable_fm) begin
         wa_q.push_back(write_addr_fm);
         wd_q.push_back(write_data_fm);
         wc_q.push_back(cyc);
      end
      if (rst_fm) begin
         fm_cnt = fm_cnt + 1;
         last_fm_cyc = cyc;
      end
      if (cpu_reset) begin
         if (!cpu_prev) first_cpu_cyc = cyc;
         cpu_cnt = cpu_cnt + 1;
      end
      cpu_prev = cpu_reset;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {22'd0, in_ready, rst_fm, write_enable_fm, cpu_reset, busy, done, chk_err,
              |write_addr_fm, |write_data_fm};
   endfunction

   task automatic start_session(input logic [31:0] b, input logic [15:0] n);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; word_count = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Leaves in_valid high so consecutive calls stream back-to-back.
   task automatic send_word(input logic [15:0] w);
      int n = 0;
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic send_sum(input logic [15:0] s);
`ifdef LOADER_CHECKSUM_EN
      send_word(s);
`endif
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      @(negedge clk);
      while (!done && n < 100) begin
         n++;
         @(negedge clk);
      end
      check(tag, {31'd0, done}, 32'd1);
   endtask

   int w0, f0, c0;
`ifdef LOADER_CHECKSUM_EN
   localparam int CPU_LAG = 1;  // extra CHECK cycle before cpu_reset
`else
   localparam int CPU_LAG = 0;
`endif

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1 check("rst_low_outs", all_outs(), 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_outs", all_outs(), 32'd0);
      check("idle_no_writes", wa_q.size(), 32'd0);

      // Back-to-back load
      w0 = wa_q.size(); f0 = fm_cnt; c0 = cpu_cnt;
      start_session(32'h20, 16'd3);
      send_word(16'hC95F); send_word(16'h639F); send_word(16'h1F3D);
      send_sum(16'h4C3B);
      wait_done("b2b_done");
      check("b2b_nwr", wa_q.size() - w0, 32'd3);
      check("b2b_a0", wa_q[w0], 32'h20);
      check("b2b_d0", wd_q[w0], 32'hC95F);
      check("b2b_a1", wa_q[w0+1], 32'h21);
      check("b2b_d1", wd_q[w0+1], 32'h639F);
      check("b2b_a2", wa_q[w0+2], 32'h22);
      check("b2b_d2", wd_q[w0+2], 32'h1F3D);
      check("b2b_consec01", wc_q[w0+1] - wc_q[w0], 32'd1);
      check("b2b_consec12", wc_q[w0+2] - wc_q[w0+1], 32'd1);
      check("b2b_fm_cycles", fm_cnt - f0, 32'd2);
      check("b2b_fm_before", {31'd0, last_fm_cyc < wc_q[w0]}, 32'd1);
      check("b2b_cpu_cycles", cpu_cnt - c0, 32'd2);
      check("b2b_cpu_after", first_cpu_cyc - wc_q[w0+2], CPU_LAG);
      check("b2b_busy", {31'd0, busy}, 32'd0);
      check("b2b_chk_err", {31'd0, chk_err}, 32'd0);
      check("hold_addr", write_addr_fm, 32'h22);
      check("hold_data", write_data_fm, 32'h1F3D);

      // 3-cycle valid gap between words 1 and 2
      w0 = wa_q.size();
      start_session(32'h20, 16'd3);
      send_word(16'hC95F);
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      send_word(16'h639F); send_word(16'h1F3D);
      send_sum(16'h4C3B);
      wait_done("gap_done");
      check("gap_nwr", wa_q.size() - w0, 32'd3);
      check("gap_a1", wa_q[w0+1], 32'h21);
      check("gap_d1", wd_q[w0+1], 32'h639F);
      check("gap_a2", wa_q[w0+2], 32'h22);
      check("gap_spacing", wc_q[w0+1] - wc_q[w0], 32'd4);

      // Address wrap
      w0 = wa_q.size();
      start_session(32'hFFFF_FFFF, 16'd2);
      send_word(16'h1234); send_word(16'hABCD);
      send_sum(16'hBE01);
      wait_done("wrap_done");
      check("wrap_nwr", wa_q.size() - w0, 32'd2);
      check("wrap_a0", wa_q[w0], 32'hFFFF_FFFF);
      check("wrap_a1", wa_q[w0+1], 32'h0000_0000);
      check("wrap_d1", wd_q[w0+1], 32'hABCD);

      // Zero-length load
      w0 = wa_q.size(); f0 = fm_cnt; c0 = cpu_cnt;
      start_session(32'h30, 16'd0);
      wait_done("zero_done");
      check("zero_nwr", wa_q.size() - w0, 32'd0);
      check("zero_fm", fm_cnt - f0, 32'd2);
      check("zero_cpu", cpu_cnt - c0, 32'd2);

      // start during LOAD is ignored
      w0 = wa_q.size();
      start_session(32'h40, 16'd3);
      send_word(16'h1111);
      in_valid = 1'b0;
      start = 1'b1; base_addr = 32'h80; word_count = 16'd1;
      @(posedge clk); #1 start = 1'b0;
      check("ign_busy", {31'd0, busy}, 32'd1);
      check("ign_ready", {31'd0, in_ready}, 32'd1);
      send_word(16'h2222); send_word(16'h3333);
      send_sum(16'h6666);
      wait_done("ign_done");
      check("ign_nwr", wa_q.size() - w0, 32'd3);
      check("ign_a1", wa_q[w0+1], 32'h41);
      check("ign_a2", wa_q[w0+2], 32'h42);

      // Reset mid-session
      w0 = wa_q.size();
      start_session(32'h60, 16'd3);
      send_word(16'h0AAA);
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_we_before", {31'd0, write_enable_fm}, 32'd1);
      @(posedge clk); #1 reset = 1'b0;
      #1 check("mid_rst_outs", all_outs(), 32'd0);
      in_valid = 1'b1; in_data = 16'h0BBB;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("mid_nwr", wa_q.size() - w0, 32'd1);
      check("mid_idle_outs", all_outs(), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      // Checksum mismatch
      w0 = wa_q.size(); c0 = cpu_cnt;
      start_session(32'h20, 16'd3);
      send_word(16'hC95F); send_word(16'h639F); send_word(16'h1F3D);
      send_sum(16'h4C3C);
      wait_done("bad_done");
      check("bad_chk_err", {31'd0, chk_err}, 32'd1);
      check("bad_cpu", cpu_cnt - c0, 32'd0);
      check("bad_nwr", wa_q.size() - w0, 32'd3);
      // Next start clears chk_err
      start_session(32'h20, 16'd0);
      check("bad_clear", {31'd0, chk_err}, 32'd0);
      wait_done("clr_done");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
